// File: rtl/missile_scheduler.sv
// rtl/missile_scheduler.sv - missile slot pool: fire arbitration, launch sequencing, occupancy, pixel merge
module missile_scheduler #(
    parameter int NSLOT      = 4,
    parameter int LAUNCH_CYC = 4,
    parameter int COOLDOWN   = 30,
    parameter int WAIT_MAX   = 255
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_clk,
    input  logic                req_p,
    input  logic                req_e,
    input  logic [9:0]          px,
    input  logic [9:0]          py,
    input  logic [9:0]          ex,
    input  logic [9:0]          ey,
    input  logic [NSLOT-1:0]    slot_explored,
    input  logic [NSLOT-1:0]    slot_is_missle,
    input  logic [16*NSLOT-1:0] slot_addr,
    output logic [NSLOT-1:0]    launch,
    output logic [9:0]          start_x,
    output logic [9:0]          start_y,
    output logic                grant_p,
    output logic                grant_e,
    output logic [NSLOT-1:0]    active,
    output logic                full,
    output logic                is_missle,
    output logic [15:0]         addr
);

    localparam int SW = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam int CW = $clog2(COOLDOWN + 1);
    localparam int LW = $clog2(LAUNCH_CYC + 1);
    localparam int WW = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t          state, state_n;
    logic            frame_q1, frame_q2, tick;
    logic            pend_p, pend_e;
    logic [CW-1:0]   cool_p, cool_e;
    logic            last_grant;          // 1: enemy got the previous shot
    logic            start_shot, win_e;
    logic            grant_now_p, grant_now_e;
    logic [SW-1:0]   slot_q, free_idx;
    logic [LW-1:0]   lau_cnt;
    logic [WW-1:0]   wait_cnt;
    logic [NSLOT-1:0] exp_q, exp_rise;
    logic [NSLOT-1:0] slot_mask, busy_mask, set_mask, clr_mask, hit;

    assign tick        = frame_q1 & ~frame_q2;
    assign full        = &active;
    assign grant_now_p = start_shot & ~win_e;
    assign grant_now_e = start_shot & win_e;
    assign exp_rise    = slot_explored & ~exp_q;
    assign clr_mask    = exp_rise & ~busy_mask;
    assign launch      = (state == S_LAUNCH) ? slot_mask : '0;

    // Frame tick: bring frame_clk into Clk domain and detect its rising edge
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_q1 <= 1'b0;
            frame_q2 <= 1'b0;
        end else begin
            frame_q1 <= frame_clk;
            frame_q2 <= frame_q1;
        end
    end

    // Lowest free slot, decoded masks for the current shot slot and the new allocation
    always_comb begin
        free_idx  = '0;
        slot_mask = '0;
        set_mask  = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!active[i]) free_idx = SW'(i);
        end
        for (int i = 0; i < NSLOT; i++) begin
            slot_mask[i] = (slot_q == SW'(i));
            set_mask[i]  = start_shot && (free_idx == SW'(i));
        end
        busy_mask = (state != S_IDLE) ? slot_mask : '0;
    end

    // Next-state logic and arbitration: alternate when both requesters are pending
    always_comb begin
        state_n    = state;
        start_shot = 1'b0;
        win_e      = pend_e & (~pend_p | ~last_grant);
        case (state)
            S_IDLE: begin
                if ((pend_p | pend_e) && !full) begin
                    start_shot = 1'b1;
                    state_n    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (lau_cnt == LW'(LAUNCH_CYC - 1)) state_n = S_WAIT;
            end
            S_WAIT: begin
                if (!slot_explored[slot_q] || (wait_cnt == WW'(WAIT_MAX - 1)))
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State register with the launch-hold and wait-timeout counters
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= S_IDLE;
            lau_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_n;
            lau_cnt  <= (state == S_LAUNCH) ? lau_cnt + LW'(1) : '0;
            wait_cnt <= (state == S_WAIT) ? wait_cnt + WW'(1) : '0;
        end
    end

    // Shot bookkeeping: slot, start position and grant pulses latched on IDLE->LAUNCH
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            slot_q     <= '0;
            start_x    <= '0;
            start_y    <= '0;
            grant_p    <= 1'b0;
            grant_e    <= 1'b0;
            last_grant <= 1'b0;
        end else begin
            grant_p <= grant_now_p;
            grant_e <= grant_now_e;
            if (start_shot) begin
                slot_q     <= free_idx;
                start_x    <= win_e ? ex : px;
                start_y    <= win_e ? ey : py;
                last_grant <= win_e;
            end
        end
    end

    // Request capture and frame cooldown; a grant reload beats a same-cycle tick
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_p <= 1'b0;
            pend_e <= 1'b0;
            cool_p <= '0;
            cool_e <= '0;
        end else begin
            if (grant_now_p)                  pend_p <= 1'b0;
            else if (req_p && cool_p == '0)   pend_p <= 1'b1;
            if (grant_now_e)                  pend_e <= 1'b0;
            else if (req_e && cool_e == '0)   pend_e <= 1'b1;

            if (grant_now_p)                  cool_p <= CW'(COOLDOWN);
            else if (tick && cool_p != '0)    cool_p <= cool_p - CW'(1);
            if (grant_now_e)                  cool_e <= CW'(COOLDOWN);
            else if (tick && cool_e != '0)    cool_e <= cool_e - CW'(1);
        end
    end

    // Occupancy: set on allocation, clear on impact edge unless the slot is mid-shot
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            exp_q  <= '0;
            active <= '0;
        end else begin
            exp_q  <= slot_explored;
            active <= (active & ~clr_mask) | set_mask;
        end
    end

    // Pixel merge: lowest-index occupied slot hitting the current pixel wins
    always_comb begin
        hit       = slot_is_missle & active;
        is_missle = |hit;
        addr      = '0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (hit[i]) addr = slot_addr[16*i +: 16];
        end
    end

endmodule

// File: tb/tb_missile_scheduler.sv
// tb/tb_missile_scheduler.sv - directed self-checking bench for missile_scheduler
module tb_missile_scheduler;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_clk;
    logic        req_p, req_e;
    logic [9:0]  px, py, ex, ey;
    logic [3:0]  slot_explored;
    logic [3:0]  slot_is_missle;
    logic [63:0] slot_addr;
    logic [3:0]  launch;
    logic [9:0]  start_x, start_y;
    logic        grant_p, grant_e;
    logic [3:0]  active;
    logic        full;
    logic        is_missle;
    logic [15:0] addr;

    int errors = 0;
    int checks = 0;
    logic seen_p, seen_e;

    missile_scheduler #(
        .NSLOT(4), .LAUNCH_CYC(4), .COOLDOWN(30), .WAIT_MAX(255)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
        .req_p(req_p), .req_e(req_e),
        .px(px), .py(py), .ex(ex), .ey(ey),
        .slot_explored(slot_explored), .slot_is_missle(slot_is_missle),
        .slot_addr(slot_addr),
        .launch(launch), .start_x(start_x), .start_y(start_y),
        .grant_p(grant_p), .grant_e(grant_e),
        .active(active), .full(full), .is_missle(is_missle), .addr(addr)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge Clk);
            seen_p = seen_p | grant_p;
            seen_e = seen_e | grant_e;
        end
    endtask

    task automatic frame_tick();
        frame_clk = 1'b1;
        step(4);
        frame_clk = 1'b0;
        step(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int extra;
        logic ok;
        Reset_n = 1'b0; frame_clk = 1'b0; req_p = 1'b0; req_e = 1'b0;
        px = '0; py = '0; ex = '0; ey = '0;
        slot_explored = '0; slot_is_missle = '0; slot_addr = '0;
        seen_p = 1'b0; seen_e = 1'b0;

        // Reset and idle
        step(3);
        Reset_n = 1'b1;
        step(100);
        check_eq("rst_launch", 32'(launch), 32'h0);
        check_eq("rst_active", 32'(active), 32'h0);
        check_eq("rst_addr", 32'(addr), 32'h0);
        check_eq("rst_is_missle", 32'(is_missle), 32'h0);
        check_eq("rst_grants", 32'({grant_p, grant_e, full}), 32'h0);
        check_eq("rst_start", 32'({start_x, start_y}), 32'h0);

        // Single player shot
        px = 10'd100; py = 10'd50; req_p = 1'b1;
        step(1);
        req_p = 1'b0;
        check_eq("p_pend_no_grant", 32'(grant_p), 32'h0);
        step(1);
        check_eq("p_grant", 32'(grant_p), 32'h1);
        check_eq("p_launch", 32'(launch), 32'h1);
        check_eq("p_start_x", 32'(start_x), 32'd100);
        check_eq("p_start_y", 32'(start_y), 32'd50);
        check_eq("p_active", 32'(active), 32'h1);
        n = 1; extra = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (launch == 4'b0001) n++;
            if (grant_p) extra++;
        end
        check_eq("p_launch_len", 32'(n), 32'd4);
        check_eq("p_grant_one_cycle", 32'(extra), 32'd0);

        // Cooldown: held request blocked for 29 ticks, granted after tick 30
        seen_p = 1'b0;
        req_p = 1'b1;
        repeat (29) frame_tick();
        check_eq("cool_29_blocked", 32'(seen_p), 32'h0);
        frame_tick();
        check_eq("cool_30_granted", 32'(seen_p), 32'h1);
        req_p = 1'b0;
        step(8);
        check_eq("cool_active", 32'(active), 32'h3);

        // Reset mid-LAUNCH drops launch asynchronously
        ex = 10'd7; ey = 10'd9; req_e = 1'b1;
        step(1);
        req_e = 1'b0;
        step(1);
        check_eq("e_launch_slot2", 32'(launch), 32'h4);
        Reset_n = 1'b0;
        #1;
        check_eq("arst_launch", 32'(launch), 32'h0);
        check_eq("arst_active", 32'(active), 32'h0);
        step(2);
        Reset_n = 1'b1;
        step(2);

        // Simultaneous requests, last_grant=player after reset -> enemy first
        px = 10'd11; py = 10'd22; ex = 10'd200; ey = 10'd300;
        req_p = 1'b1; req_e = 1'b1;
        step(1);
        req_p = 1'b0; req_e = 1'b0;
        step(1);
        check_eq("both_e_grant", 32'({grant_e, grant_p}), 32'h2);
        check_eq("both_e_start", 32'({start_x, start_y}), 32'({10'd200, 10'd300}));
        check_eq("both_e_launch", 32'(launch), 32'h1);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step(1);
            if (grant_p) ok = 1'b1;
        end
        check_eq("both_p_follows", 32'(ok), 32'h1);
        check_eq("both_p_launch", 32'(launch), 32'h2);
        check_eq("both_p_start_x", 32'(start_x), 32'd11);

        // Second simultaneous round after cooldowns: enemy again (last was player)
        step(6);
        repeat (30) frame_tick();
        ex = 10'd201;
        req_p = 1'b1; req_e = 1'b1;
        step(1);
        req_p = 1'b0; req_e = 1'b0;
        step(1);
        check_eq("alt_e_first", 32'({grant_e, grant_p}), 32'h2);
        check_eq("alt_e_launch", 32'(launch), 32'h4);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step(1);
            if (grant_p) ok = 1'b1;
        end
        check_eq("alt_p_second", 32'(ok), 32'h1);
        check_eq("alt_p_launch", 32'(launch), 32'h8);
        step(8);
        check_eq("fill_full", 32'(full), 32'h1);
        check_eq("fill_active", 32'(active), 32'hF);

        // Full: enemy request persists, granted into freed slot 2
        ex = 10'd333;
        seen_e = 1'b0;
        req_e = 1'b1;
        repeat (30) frame_tick();
        req_e = 1'b0;
        step(4);
        check_eq("full_no_grant", 32'(seen_e), 32'h0);
        slot_explored = 4'b0100;
        ok = 1'b0;
        for (int i = 0; i < 3 && !ok; i++) begin
            step(1);
            if (grant_e) ok = 1'b1;
        end
        check_eq("free_e_grant", 32'(ok), 32'h1);
        check_eq("free_e_launch", 32'(launch), 32'h4);
        check_eq("free_e_start_x", 32'(start_x), 32'd333);
        slot_explored = 4'b0000;
        step(8);
        check_eq("free_active", 32'(active), 32'hF);

        // Pixel merge
        slot_addr = {16'hBBBB, 16'h0034, 16'h0012, 16'hAAAA};
        slot_is_missle = 4'b0110;
        #1;
        check_eq("pix_is_missle", 32'(is_missle), 32'h1);
        check_eq("pix_addr_s1", 32'(addr), 32'h0012);
        slot_explored = 4'b0010;
        step(2);
        check_eq("pix_active", 32'(active), 32'hD);
        check_eq("pix_addr_s2", 32'(addr), 32'h0034);
        slot_is_missle = 4'b0010;
        #1;
        check_eq("pix_none_hit", 32'(is_missle), 32'h0);
        check_eq("pix_none_addr", 32'(addr), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
